// File: rtl/instr_mem_loader_if.sv
// Byte-stream / instruction-memory bus of the program loader.
// The master modport drives load requests and received bytes; the slave modport
// (the loader) drives the memory write port and the status flags.
interface instr_mem_loader_if #(
  parameter int NBITS = 32
);
  logic             i_start_load;
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             o_mem_we;
  logic [NBITS-1:0] o_mem_addr;
  logic [NBITS-1:0] o_mem_data;
  logic             o_cpu_enable;
  logic             o_busy;
  logic             o_done;
  logic             o_error;

  modport master (
    output i_start_load, i_rx_data, i_rx_valid,
    input  o_mem_we, o_mem_addr, o_mem_data, o_cpu_enable, o_busy, o_done, o_error
  );

  modport slave (
    input  i_start_load, i_rx_data, i_rx_valid,
    output o_mem_we, o_mem_addr, o_mem_data, o_cpu_enable, o_busy, o_done, o_error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles received bytes (MSB first) into words and
// writes them to consecutive word addresses until a halt word (all ones) or the
// last memory word is written. Word assembly assumes four bytes per word.
// Optional feature: define LOADER_TIMEOUT_EN to abort a load after TIMEOUT_CYC
// idle cycles without a byte (load ends in DONE with o_error set).
module instr_mem_loader #(
  parameter int NBITS       = 32,
  parameter int CELDAS      = 60,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(4 * ((CELDAS - 1) / 4));
  localparam logic [NBITS-1:0] ADDR_STEP = NBITS'(4);

  // A word of all ones marks the end of the program.
  function automatic logic is_halt(input logic [NBITS-1:0] word);
    return &word;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [NBITS-9:0] asm_q, asm_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [NBITS-1:0] mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_data_q, mem_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             cpu_en_q, cpu_en_d;

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Next-state and output logic; the finishing decision is taken in the write cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start_load) begin
          state_d = S_LOAD;
          cnt_d   = 2'd0;
          addr_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (we_q && (is_halt(mem_data_q) || (mem_addr_q == LAST_ADDR))) begin
          // Transition cycle: bytes arriving now are dropped.
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = !is_halt(mem_data_q);
          cnt_d   = 2'd0;
        end else if (bus.i_rx_valid) begin
`ifdef LOADER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (cnt_q == 2'd3) begin
            we_d       = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = {asm_q, bus.i_rx_data};
            addr_d     = addr_q + ADDR_STEP;
            cnt_d      = 2'd0;
          end else begin
            asm_d = {asm_q[NBITS-17:0], bus.i_rx_data};
            cnt_d = cnt_q + 2'd1;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (to_cnt_q == TO_LIMIT) begin
          // Idle too long: drop the partial word and finish with an error.
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
          cnt_d   = 2'd0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`else
        else begin
          state_d = S_LOAD;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d   = (state_d == S_LOAD);
    cpu_en_d = (state_d == S_DONE) && !error_d;
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      asm_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_en_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_en_q   <= cpu_en_d;
`ifdef LOADER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = error_q;
  assign bus.o_cpu_enable = cpu_en_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: random byte streams are compared
// against a word-chunking reference model (writes, write cycle, final status).
module tb_instr_mem_loader;
  localparam int NBITS = 32;
  localparam int CELDAS = 60;
  localparam int TO_CYC = 20;
  localparam logic [31:0] LAST_ADDR = 32'(4 * ((CELDAS - 1) / 4));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.NBITS(NBITS)) bus ();
  instr_mem_loader #(.NBITS(NBITS), .CELDAS(CELDAS), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  logic [7:0]  stim_b[$];
  int          stim_c[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle with the write strobe high.
  always @(negedge clk) begin
    if (bus.o_mem_we === 1'b1) begin
      got_addr.push_back(bus.o_mem_addr);
      got_data.push_back(bus.o_mem_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    bus.i_rx_valid   = v;
    bus.i_rx_data    = d;
    bus.i_start_load = s;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) stim_b.push_back(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  task automatic clear_got();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
  endtask

  // Start a load and feed stim_b with random gaps; optionally pulse start with bytes.
  task automatic play(input int max_gap, input bit inject_start);
    clear_got();
    stim_c.delete();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    vectors++;
    if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL start_status busy=%b done=%b expected busy=1 done=0", bus.o_busy, bus.o_done);
    end
    foreach (stim_b[i]) begin
      repeat ($urandom_range(0, max_gap)) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, stim_b[i], inject_start && ($urandom_range(0, 2) == 0));
      stim_c.push_back(cyc);
    end
    repeat (6) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Reference: bytes chunk into words; stop after halt or the last address.
  task automatic check_load(input string tag);
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    int          e_cyc[$];
    logic [31:0] a = 32'h0;
    logic [31:0] w;
    bit term = 1'b0;
    bit err = 1'b0;
    int n;
    for (int i = 0; i + 3 < stim_b.size() && !term; i += 4) begin
      w = {stim_b[i], stim_b[i+1], stim_b[i+2], stim_b[i+3]};
      e_addr.push_back(a); e_data.push_back(w); e_cyc.push_back(stim_c[i+3] + 1);
      if (w == 32'hFFFF_FFFF) begin term = 1'b1; err = 1'b0; end
      else if (a == LAST_ADDR) begin term = 1'b1; err = 1'b1; end
      else a = a + 32'd4;
    end
    vectors++;
    if (got_addr.size() != e_addr.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d expected %0d", tag, got_addr.size(), e_addr.size());
    end
    n = (got_addr.size() < e_addr.size()) ? got_addr.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_addr[i] !== e_addr[i] || got_data[i] !== e_data[i] || got_cyc[i] != e_cyc[i]) begin
        errors++;
        $display("FAIL %s write%0d got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 tag, i, got_addr[i], got_data[i], got_cyc[i], e_addr[i], e_data[i], e_cyc[i]);
      end
    end
    vectors++;
    if (term) begin
      if (bus.o_done !== 1'b1 || bus.o_error !== err || bus.o_cpu_enable !== !err || bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s final done=%b err=%b cpu=%b busy=%b expected done=1 err=%b cpu=%b busy=0",
                 tag, bus.o_done, bus.o_error, bus.o_cpu_enable, bus.o_busy, err, !err);
      end
    end else begin
      if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s final busy=%b done=%b expected busy=1 done=0", tag, bus.o_busy, bus.o_done);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, bus.o_cpu_enable,
         bus.o_busy, bus.o_done, bus.o_error} !== 69'h0) begin
      errors++;
      $display("FAIL %s outputs we=%b addr=%h data=%h cpu=%b busy=%b done=%b err=%b expected all 0",
               tag, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, bus.o_cpu_enable,
               bus.o_busy, bus.o_done, bus.o_error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start_load = 1'b0; bus.i_rx_valid = 1'b0; bus.i_rx_data = 8'h00;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    stim_b = '{8'h8C, 8'h22, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    play(0, 1'b0);
    check_load("directed");
  endtask

  task automatic test_back_to_back();
    stim_b.delete();
    repeat (3) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    repeat (5) stim_b.push_back(8'($urandom()));
    play(0, 1'b0);
    check_load("back_to_back");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      stim_b.delete();
      repeat ($urandom_range(1, 6)) push_word(rand_word());
      push_word(32'hFFFF_FFFF);
      repeat ($urandom_range(0, 6)) stim_b.push_back(8'($urandom()));
      play(3, 1'b0);
      check_load("random");
    end
  endtask

  task automatic test_overflow();
    stim_b.delete();
    repeat (16) push_word(rand_word());
    play(1, 1'b0);
    check_load("overflow");
  endtask

  task automatic test_ignore();
    clear_got();
    repeat (8) drive(1'b1, 8'($urandom()), 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    vectors++;
    if (got_addr.size() != 0 || bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_rx writes=%0d done=%b expected writes=0 done=1", got_addr.size(), bus.o_done);
    end
    stim_b.delete();
    repeat (4) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    play(2, 1'b1);
    check_load("ignore_start");
  endtask

  task automatic test_reset_mid();
    clear_got();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    vectors++;
    if (got_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_write writes=%0d expected 0", got_addr.size());
    end
    stim_b.delete();
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    play(1, 1'b0);
    check_load("after_reset");
  endtask

  task automatic test_timeout();
    stim_b = '{8'h11, 8'h22, 8'h33};
    play(0, 1'b0);
    repeat (30) drive(1'b0, 8'h00, 1'b0);
    vectors++;
`ifdef LOADER_TIMEOUT_EN
    if (got_addr.size() != 0 || bus.o_done !== 1'b1 || bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout writes=%0d done=%b err=%b busy=%b expected 0 1 1 0",
               got_addr.size(), bus.o_done, bus.o_error, bus.o_busy);
    end
`else
    if (got_addr.size() != 0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout writes=%0d done=%b busy=%b expected 0 0 1",
               got_addr.size(), bus.o_done, bus.o_busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_overflow();
    test_ignore();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
